// File: rtl/ir_cmd_pkg.sv
// rtl/ir_cmd_pkg.sv - command encodings, key map and scheduler states for ir_cmd_scheduler
package ir_cmd_pkg;

  typedef enum logic [2:0] {
    STOP = 3'd0,
    CMD1 = 3'd1,
    CMD2 = 3'd2,
    CMD3 = 3'd3,
    CMD4 = 3'd4,
    CMD5 = 3'd5
  } ir_cmd_t;

  localparam logic [7:0] KEY_1    = 8'h01;
  localparam logic [7:0] KEY_2    = 8'h02;
  localparam logic [7:0] KEY_3    = 8'h03;
  localparam logic [7:0] KEY_4    = 8'h04;
  localparam logic [7:0] KEY_5    = 8'h05;
  localparam logic [7:0] KEY_STOP = 8'h12;

  typedef struct packed {
    logic    hit;
    ir_cmd_t cmd;
  } key_map_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } sched_state_t;

  function automatic key_map_t key_to_cmd(input logic [7:0] key);
    key_map_t m;
    m.hit = 1'b1;
    m.cmd = STOP;
    case (key)
      KEY_1:    m.cmd = CMD1;
      KEY_2:    m.cmd = CMD2;
      KEY_3:    m.cmd = CMD3;
      KEY_4:    m.cmd = CMD4;
      KEY_5:    m.cmd = CMD5;
      KEY_STOP: m.cmd = STOP;
      default:  m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous command FIFO; a push on full is honoured only alongside a pop
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ir_cmd_scheduler.sv
// rtl/ir_cmd_scheduler.sv - validates NEC frames, suppresses repeats, queues commands and hands them to the transmitter
module ir_cmd_scheduler
  import ir_cmd_pkg::*;
#(
  parameter logic [15:0] ADDR           = 16'h6B86,
  parameter int          FIFO_DEPTH     = 4,
  parameter int          HOLDOFF_CYCLES = 12_500_000,
  parameter int          TX_TIMEOUT     = 5_000_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   ir_data,
  input  logic                          data_ready,
  input  logic                          resend,
  output logic                          tx_start,
  output logic [2:0]                    tx_cmd,
  input  logic                          tx_done,
  output logic [2:0]                    state_control,
  output logic                          toggle,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_error,
  output logic                          tx_error
);

  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam int TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

  sched_state_t  state, next_state;
  key_map_t      km;
  logic          frame_ok, repeat_hit, accept;
  logic          ir_push;
  ir_cmd_t       ir_cmd_q;
  logic [7:0]    last_key;
  logic          last_vld;
  ir_cmd_t       last_cmd;
  logic [HW-1:0] holdoff_cnt;
  logic          resend_pend, resend_push;
  logic          push, pop, full, empty;
  logic [2:0]    push_data, pop_data;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_expire;

  assign km         = key_to_cmd(ir_data[23:16]);
  assign frame_ok   = (ir_data[31:24] == ~ir_data[23:16]) && (ir_data[15:0] == ADDR);
  assign repeat_hit = last_vld && (ir_data[23:16] == last_key) && (holdoff_cnt != '0);
  assign accept     = data_ready && frame_ok && km.hit && !repeat_hit;

  // A pending resend yields to an IR enqueue and then uses the newest last_cmd.
  assign resend_push = resend_pend && !ir_push && last_vld;
  assign push        = ir_push || resend_push;
  assign push_data   = ir_push ? ir_cmd_q : last_cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_push     <= 1'b0;
      ir_cmd_q    <= STOP;
      last_key    <= '0;
      last_vld    <= 1'b0;
      last_cmd    <= STOP;
      holdoff_cnt <= '0;
      resend_pend <= 1'b0;
      frame_error <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      ir_push     <= accept;
      ir_cmd_q    <= km.cmd;
      frame_error <= frame_error || (data_ready && !frame_ok);
      overflow    <= overflow || (push && full && !pop);
      if (accept) begin
        last_key    <= ir_data[23:16];
        last_vld    <= 1'b1;
        last_cmd    <= km.cmd;
        holdoff_cnt <= HW'(HOLDOFF_CYCLES - 1);
      end else if (holdoff_cnt != '0) begin
        holdoff_cnt <= holdoff_cnt - 1'b1;
      end
      if (resend)        resend_pend <= 1'b1;
      else if (!ir_push) resend_pend <= 1'b0;
    end
  end

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(3)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  assign tmo_expire = (state == WAIT) && !tx_done && (tmo_cnt == TW'(TX_TIMEOUT - 1));
  assign tx_start   = (state == START);

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = START;
        end
      end
      START:   next_state = WAIT;
      WAIT:    if (tx_done || tmo_expire) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Command outputs are captured on the pop edge so they are valid throughout START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tx_cmd        <= '0;
      state_control <= '0;
      toggle        <= 1'b0;
      tmo_cnt       <= '0;
      tx_error      <= 1'b0;
    end else begin
      state    <= next_state;
      tx_error <= tx_error || tmo_expire;
      if (pop) begin
        tx_cmd        <= pop_data;
        state_control <= pop_data;
        toggle        <= ~toggle;
      end
      if (state == START)     tmo_cnt <= '0;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// tb/tb_ir_cmd_scheduler.sv - directed self-checking bench for ir_cmd_scheduler
module tb_ir_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ir_data = '0;
  logic        data_ready = 1'b0;
  logic        resend = 1'b0;
  logic        tx_start;
  logic [2:0]  tx_cmd;
  logic        tx_done = 1'b0;
  logic [2:0]  state_control;
  logic        toggle;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        frame_error;
  logic        tx_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts = 0;
  int last_start = 0;
  int s0, start1, err_cyc;
  bit auto_ack = 1'b0;
  bit ack_pipe = 1'b0;

  ir_cmd_scheduler #(
    .ADDR(16'h6B86), .FIFO_DEPTH(4), .HOLDOFF_CYCLES(100), .TX_TIMEOUT(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ir_data(ir_data), .data_ready(data_ready),
    .resend(resend), .tx_start(tx_start), .tx_cmd(tx_cmd), .tx_done(tx_done),
    .state_control(state_control), .toggle(toggle), .fifo_level(fifo_level),
    .overflow(overflow), .frame_error(frame_error), .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (tx_start) begin
      starts++;
      last_start = cyc;
    end
    if (auto_ack) begin
      tx_done  = ack_pipe;
      ack_pipe = tx_start;
    end
  endtask

  task automatic frame(input logic [7:0] key);
    ir_data    = {~key, key, 16'h6B86};
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  task automatic raw_frame(input logic [31:0] d);
    ir_data    = d;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int bound);
    bit found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      tick();
      if (tx_start) found = 1'b1;
    end
    check(tag, 32'(found), 1);
  endtask

  task automatic ack_once();
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    tick();
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_cmd", 32'(tx_cmd), 0);
    check("rst_state_control", 32'(state_control), 0);
    check("rst_toggle", 32'(toggle), 0);
    check("rst_fifo_level", 32'(fifo_level), 0);
    check("rst_flags", 32'({overflow, frame_error, tx_error}), 0);
    rst_n = 1'b1;
    tick();

    // Basic latency and handshake
    frame(8'h01);
    tick();
    check("lat_no_start_early", 32'(tx_start), 0);
    tick();
    check("lat_tx_start", 32'(tx_start), 1);
    check("lat_tx_cmd", 32'(tx_cmd), 1);
    check("lat_state_control", 32'(state_control), 1);
    check("lat_toggle", 32'(toggle), 1);
    check("lat_fifo_level", 32'(fifo_level), 0);
    repeat (9) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;

    // Bad complement and bad address
    s0 = starts;
    raw_frame(32'hFF01_6B86);
    raw_frame(32'hFE01_1234);
    repeat (60) tick();
    check("ferr_flag", 32'(frame_error), 1);
    check("ferr_no_start", 32'(starts - s0), 0);
    check("ferr_fifo_level", 32'(fifo_level), 0);
    check("done_no_timeout", 32'(tx_error), 0);

    // Hold-off window of 100 cycles
    auto_ack = 1'b1;
    s0 = starts;
    frame(8'h02);
    repeat (19) tick();
    frame(8'h02);
    repeat (19) tick();
    frame(8'h02);
    repeat (79) tick();
    check("hold_one_start", 32'(starts - s0), 1);
    check("hold_fifo_empty", 32'(fifo_level), 0);
    frame(8'h02);
    repeat (2) tick();
    check("hold_after_window", 32'(starts - s0), 2);
    check("hold_after_cmd", 32'(tx_cmd), 2);
    repeat (7) tick();
    frame(8'h03);
    repeat (2) tick();
    check("hold_diff_key", 32'(starts - s0), 3);
    check("hold_diff_cmd", 32'(tx_cmd), 3);
    repeat (4) tick();
    auto_ack = 1'b0;
    tx_done  = 1'b0;
    ack_pipe = 1'b0;

    // Overflow with tx_done withheld
    s0 = starts;
    frame(8'h01);
    frame(8'h02);
    frame(8'h04);
    frame(8'h05);
    frame(8'h12);
    frame(8'h03);
    repeat (3) tick();
    start1 = last_start;
    check("ovf_one_start", 32'(starts - s0), 1);
    check("ovf_tx_cmd", 32'(tx_cmd), 1);
    check("ovf_level", 32'(fifo_level), 4);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_no_tx_error_yet", 32'(tx_error), 0);

    // Timeout, then the next queued command issues
    err_cyc = 0;
    for (int i = 0; i < 100 && err_cyc == 0; i++) begin
      tick();
      if (tx_error) err_cyc = cyc;
    end
    check("tmo_error_cycle", 32'(err_cyc - start1), 51);
    wait_start("tmo_next_start", 5);
    check("tmo_next_delay", 32'(last_start - start1), 52);
    check("tmo_next_cmd", 32'(tx_cmd), 2);
    check("tmo_toggle", 32'(toggle), 32'(starts[0]));
    check("tmo_level", 32'(fifo_level), 3);

    // Asynchronous reset while waiting
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_outputs", 32'({tx_start, tx_cmd, state_control, toggle}), 0);
    check("arst_fifo_level", 32'(fifo_level), 0);
    check("arst_flags", 32'({overflow, frame_error, tx_error}), 0);
    tick();
    starts = 0;
    rst_n  = 1'b1;

    // Resend before any accepted key
    resend = 1'b1;
    tick();
    resend = 1'b0;
    repeat (6) tick();
    check("resend_empty_starts", 32'(starts), 0);
    check("resend_empty_level", 32'(fifo_level), 0);

    // Resend coinciding with an IR enqueue
    frame(8'h05);
    resend = 1'b1;
    tick();
    resend = 1'b0;
    check("resend_level_a", 32'(fifo_level), 1);
    tick();
    check("resend_first_start", 32'(tx_start), 1);
    check("resend_first_cmd", 32'(tx_cmd), 5);
    check("resend_level_b", 32'(fifo_level), 1);
    ack_once();
    wait_start("resend_second_start", 6);
    check("resend_second_cmd", 32'(tx_cmd), 5);
    check("resend_level_c", 32'(fifo_level), 0);
    check("resend_toggle", 32'(toggle), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
